// File: rtl/cache_valid_array.sv
// Set-associative valid-bit array with registered per-set read, per-way write and a
// one-set-per-cycle flush sweep. Optional dirty array enabled by CACHE_VALID_DIRTY_EN.
module cache_valid_array #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 2,
  parameter int INDEX_W  = $clog2(NUM_SETS),
  parameter int WAY_W    = (NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1)
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic                RdEn,
  input  logic [INDEX_W-1:0]  RdIndex,
  output logic [NUM_WAYS-1:0] RdValid,
  input  logic                WrEn,
  input  logic [INDEX_W-1:0]  WrIndex,
  input  logic [WAY_W-1:0]    WrWay,
  input  logic                WrValid,
  input  logic                FlushReq,
`ifdef CACHE_VALID_DIRTY_EN
  input  logic                WrDirty,
  output logic [NUM_WAYS-1:0] RdDirty,
  output logic                FlushDirtySeen,
`endif
  output logic                FlushBusy,
  output logic                FlushDone
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_SETS - 1);

  state_e                             state_q, state_d;
  logic [INDEX_W-1:0]                 cnt_q, cnt_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q, valid_d;
  logic [NUM_WAYS-1:0]                rd_valid_q, rd_valid_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic [NUM_WAYS-1:0]                way_mask_s;
  logic                               idle_s;
  logic                               wr_ok_s;

  assign idle_s  = (state_q == ST_IDLE);
  // A simultaneous flush request takes priority and drops the write.
  assign wr_ok_s = WrEn & idle_s & ~FlushReq;

  // One-hot way select; an out-of-range WrWay yields an empty mask and writes nothing.
  always_comb begin
    way_mask_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_mask_s[w] = (WrWay == WAY_W'(w));
    end
  end

  // Flush sequencer next-state and sweep counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (FlushReq) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  // Valid array update and read path; the read sees valid_d, giving write-first bypass.
  always_comb begin
    valid_d = valid_q;
    if (state_q == ST_FLUSH) begin
      valid_d[cnt_q] = '0;
    end else if (wr_ok_s) begin
      valid_d[WrIndex] = (valid_q[WrIndex] & ~way_mask_s) | (way_mask_s & {NUM_WAYS{WrValid}});
    end else begin
      valid_d = valid_q;
    end
    if (!RdEn) begin
      rd_valid_d = rd_valid_q;
    end else if (!idle_s) begin
      rd_valid_d = '0;
    end else begin
      rd_valid_d = valid_d[RdIndex];
    end
  end

  // State, counter, array and output registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      rd_valid_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign RdValid   = rd_valid_q;
  assign FlushBusy = busy_q;
  assign FlushDone = done_q;

`ifdef CACHE_VALID_DIRTY_EN
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  dirty_q, dirty_d;
  logic [NUM_WAYS-1:0]                rd_dirty_q, rd_dirty_d;
  logic                               seen_q, seen_d;

  // Dirty array mirrors the valid array; clearing a valid bit also clears its dirty bit.
  always_comb begin
    dirty_d = dirty_q;
    seen_d  = seen_q;
    if (state_q == ST_FLUSH) begin
      dirty_d[cnt_q] = '0;
      seen_d         = seen_q | (|(valid_q[cnt_q] & dirty_q[cnt_q]));
    end else if (idle_s && FlushReq) begin
      seen_d = 1'b0;
    end else if (wr_ok_s) begin
      dirty_d[WrIndex] = (dirty_q[WrIndex] & ~way_mask_s) |
                         (way_mask_s & {NUM_WAYS{WrValid & WrDirty}});
    end else begin
      dirty_d = dirty_q;
    end
    if (!RdEn) begin
      rd_dirty_d = rd_dirty_q;
    end else if (!idle_s) begin
      rd_dirty_d = '0;
    end else begin
      rd_dirty_d = dirty_d[RdIndex];
    end
  end

  // Dirty state registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      dirty_q    <= '0;
      rd_dirty_q <= '0;
      seen_q     <= 1'b0;
    end else begin
      dirty_q    <= dirty_d;
      rd_dirty_q <= rd_dirty_d;
      seen_q     <= seen_d;
    end
  end

  assign RdDirty        = rd_dirty_q;
  assign FlushDirtySeen = seen_q;
`endif

endmodule

// File: tb/tb_cache_valid_array.sv
// Scoreboard bench for cache_valid_array: a set/way bit-array model predicts read data
// and flush handshake; a monitor pops expected read vectors one cycle after each RdEn.
module tb_cache_valid_array;
  localparam int NS = 64;
  localparam int NW = 2;
  localparam int IW = 6;
  localparam int WW = 1;

  logic          Clk = 1'b0;
  logic          ResetN = 1'b0;
  logic          RdEn = 1'b0;
  logic [IW-1:0] RdIndex = '0;
  logic [NW-1:0] RdValid;
  logic          WrEn = 1'b0;
  logic [IW-1:0] WrIndex = '0;
  logic [WW-1:0] WrWay = '0;
  logic          WrValid = 1'b0;
  logic          FlushReq = 1'b0;
  logic          FlushBusy;
  logic          FlushDone;
`ifdef CACHE_VALID_DIRTY_EN
  logic          WrDirty = 1'b0;
  logic [NW-1:0] RdDirty;
  logic          FlushDirtySeen;
`endif

  always #5 Clk = ~Clk;

  cache_valid_array #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .RdEn(RdEn), .RdIndex(RdIndex), .RdValid(RdValid),
    .WrEn(WrEn), .WrIndex(WrIndex), .WrWay(WrWay), .WrValid(WrValid),
    .FlushReq(FlushReq),
`ifdef CACHE_VALID_DIRTY_EN
    .WrDirty(WrDirty), .RdDirty(RdDirty), .FlushDirtySeen(FlushDirtySeen),
`endif
    .FlushBusy(FlushBusy), .FlushDone(FlushDone)
  );

  int checks = 0;
  int errors = 0;
  logic [NW-1:0] exp_q[$];

  // Reference model: plain bit table plus flush phase (0 idle, 1 sweeping, 2 done).
  bit mem[NS][NW];
  int phase = 0;
  int left  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        mem[s][w] = 1'b0;
  endtask

  function automatic logic [NW-1:0] row(input int s);
    logic [NW-1:0] r;
    for (int w = 0; w < NW; w++) r[w] = mem[s][w];
    return r;
  endfunction

  task automatic step(input bit rd, input int ri, input bit wr, input int wi,
                      input int ww, input bit wv, input bit fr);
    logic [NW-1:0] e;
    @(negedge Clk);
    RdEn = rd; RdIndex = IW'(ri); WrEn = wr; WrIndex = IW'(wi);
    WrWay = WW'(ww); WrValid = wv; FlushReq = fr;
    e = '0;
    if (phase == 0) begin
      if (fr) begin
        e = row(ri);
        model_clear();
        phase = 1;
        left  = NS;
      end else begin
        if (wr && ww < NW) mem[wi][ww] = wv;
        e = row(ri);
      end
    end else if (phase == 1) begin
      left--;
      if (left == 0) phase = 2;
    end else begin
      phase = 0;
    end
    if (rd) exp_q.push_back(e);
    @(posedge Clk);
    #1;
    check("flush_busy", FlushBusy, (phase == 1));
    check("flush_done", FlushDone, (phase == 2));
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: any read issued at an edge is checked against the scoreboard just after it.
  initial begin
    bit fire;
    forever begin
      @(posedge Clk);
      fire = RdEn && ResetN;
      #1;
      if (fire) begin
        if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_valid", RdValid, exp_q.pop_front());
      end
    end
  end

  initial begin
    model_clear();
    repeat (3) @(posedge Clk);
    #1;
    check("reset_rdvalid", RdValid, 32'd0);
    check("reset_busy", FlushBusy, 32'd0);
    check("reset_done", FlushDone, 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;

    step(1'b1, 5, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 3, 1, 1'b1, 1'b0);
    step(1'b1, 3, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 7, 1'b1, 7, 0, 1'b1, 1'b0);
    idle();

    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        step(1'b0, 0, 1'b1, s, w, 1'b1, 1'b0);
    step(1'b1, 9, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < NS + 2; i++)
      step(1'b1, i % NS, (i == 10), 0, 0, 1'b1, (i == 30));
    for (int s = 0; s < NS; s++)
      step(1'b1, s, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7), $urandom_range(0, NW - 1), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) == 0));
    while (phase != 0) idle();

    for (int s = 0; s < 8; s++)
      step(1'b0, 0, 1'b1, s, s % NW, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    repeat (19) idle();
    @(negedge Clk);
    #2;
    ResetN = 1'b0;
    #1;
    check("async_busy", FlushBusy, 32'd0);
    check("async_done", FlushDone, 32'd0);
    check("async_rdvalid", RdValid, 32'd0);
    model_clear();
    phase = 0;
    left  = 0;
    @(negedge Clk);
    ResetN = 1'b1;
    repeat (70) idle();
    for (int s = 0; s < 8; s++)
      step(1'b1, s, 1'b0, 0, 0, 1'b0, 1'b0);
    idle();
    idle();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
